// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Data-memory responder that stalls the core. It takes one request at a
//   time over a valid/ready handshake and services it from an internal array
//   of 16-bit words. Each request gets a single-cycle response pulse exactly
//   LATENCY cycles after the cycle in which it was accepted.
//
// Handshake: a request transfers on any rising edge where req_valid and
//   req_ready are both high. req_ready is low only while a request is
//   waiting (WAIT). The req_* inputs are not looked at outside the accept
//   edge. resp_valid is a one-cycle pulse. resp_rdata and resp_err keep
//   their values until the next response.
//
// Parameters
//   LATENCY    edges from request acceptance to response (1..15)
//   ADDR_W     word-address bits; the array holds 2**ADDR_W words
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   req_valid   request present
//   req_wr      1 = write, 0 = read
//   req_addr    byte address (must be even)
//   req_wdata   write data
//   req_ready   responder can accept a request this cycle
//   resp_valid  one-cycle completion pulse
//   resp_rdata  read data; 0 for writes and errors
//   resp_err    misaligned or out-of-range address (qualified by resp_valid)
//   busy        a request is outstanding (WAIT)
//   state_dbg   current FSM state (0 = IDLE, 1 = WAIT, 2 = RESP)
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  // The edge that accepts a request is WAIT's first edge, so the counter
  // starts two below LATENCY. The edge where it reaches zero enters RESP.
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] mem [2**ADDR_W];

  logic              accept;
  logic              do_access;
  logic              a_wr;
  logic [15:0]       a_addr;
  logic [15:0]       a_wdata;
  logic              a_err;
  logic [ADDR_W-1:0] a_idx;

  assign req_ready  = (state != WAIT);
  assign busy       = (state == WAIT);
  assign resp_valid = (state == RESP);
  assign state_dbg  = state;

  // The access happens on the edge that enters RESP. When LATENCY is 1,
  // that edge is also the accept edge, so the live request fields are used.
  always_comb begin
    accept    = req_valid && (state != WAIT);
    a_wr      = wr_q;
    a_addr    = addr_q;
    a_wdata   = wdata_q;
    do_access = (state == WAIT) && (cnt == 4'd0);
    if (LATENCY == 1) begin
      a_wr      = req_wr;
      a_addr    = req_addr;
      a_wdata   = req_wdata;
      do_access = accept;
    end
    a_err = a_addr[0] | ((a_addr >> (ADDR_W + 1)) != 16'd0);
    a_idx = a_addr[ADDR_W:1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      wr_q       <= 1'b0;
      addr_q     <= 16'd0;
      wdata_q    <= 16'd0;
      resp_rdata <= 16'd0;
      resp_err   <= 1'b0;
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= 16'd0;
    end else begin
      if (do_access) begin
        if (a_err) begin
          resp_err   <= 1'b1;
          resp_rdata <= 16'd0;
        end else begin
          resp_err <= 1'b0;
          if (a_wr) begin
            mem[a_idx] <= a_wdata;
            resp_rdata <= 16'd0;
          end else begin
            resp_rdata <= mem[a_idx];
          end
        end
      end

      case (state)
        IDLE, RESP: begin
          if (accept) begin
            wr_q    <= req_wr;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Directed bench for mem_responder. It uses two instances that share the
//   request fields and the reset: u4 has LATENCY=4 and u1 has LATENCY=1. Both
//   use ADDR_W=8. Inputs change 1 ns after a rising edge. Outputs are sampled
//   at the same point.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = 16'd0;
  logic [15:0] req_wdata = 16'd0;
  logic        v4 = 1'b0, v1 = 1'b0;

  logic        rdy4, rv4, err4, busy4;
  logic [15:0] rd4;
  logic [1:0]  st4;
  logic        rdy1, rv1, err1, busy1;
  logic [15:0] rd1;
  logic [1:0]  st1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(4), .ADDR_W(8)) u4 (
    .clk(clk), .rst(rst), .req_valid(v4), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(rdy4), .resp_valid(rv4), .resp_rdata(rd4),
    .resp_err(err4), .busy(busy4), .state_dbg(st4)
  );

  mem_responder #(.LATENCY(1), .ADDR_W(8)) u1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(rdy1), .resp_valid(rv1), .resp_rdata(rd1),
    .resp_err(err1), .busy(busy1), .state_dbg(st1)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents one request to the selected instance for a single edge.
  task automatic drive_req(input bit l1, input logic wr, input logic [15:0] a,
                           input logic [15:0] d);
    req_wr = wr; req_addr = a; req_wdata = d;
    if (l1) v1 = 1'b1; else v4 = 1'b1;
    step();
    v1 = 1'b0; v4 = 1'b0;
  endtask

  // Call right after the accept edge. n counts cycles from the accepting
  // cycle until resp_valid is seen, bounded at 40. not_ready counts the
  // cycles in which req_ready was low along the way.
  task automatic wait_resp(input bit l1, output int n, output int not_ready);
    n = 1; not_ready = 0;
    while (!(l1 ? rv1 : rv4) && n < 40) begin
      if (!(l1 ? rdy1 : rdy4)) not_ready++;
      step();
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    tests_run++; if (rdy4 !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%b exp=1", rdy4); end
    tests_run++; if (rv4 !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid got=%b exp=0", rv4); end
    tests_run++; if (rd4 !== 16'h0000) begin tests_failed++; $display("FAIL reset_rdata got=%h exp=0000", rd4); end
    tests_run++; if (err4 !== 1'b0) begin tests_failed++; $display("FAIL reset_err got=%b exp=0", err4); end
    tests_run++; if (busy4 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy4); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_write_latency();
    int n, nr;
    drive_req(1'b0, 1'b1, 16'h0010, 16'h1234);
    tests_run++; if (busy4 !== 1'b1) begin tests_failed++; $display("FAIL wr_busy_after_accept got=%b exp=1", busy4); end
    wait_resp(1'b0, n, nr);
    tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL wr_latency got=%0d exp=4", n); end
    tests_run++; if (nr !== 3) begin tests_failed++; $display("FAIL wr_ready_low_cycles got=%0d exp=3", nr); end
    tests_run++; if (err4 !== 1'b0) begin tests_failed++; $display("FAIL wr_err got=%b exp=0", err4); end
    tests_run++; if (rd4 !== 16'h0000) begin tests_failed++; $display("FAIL wr_rdata got=%h exp=0000", rd4); end
    step();
    tests_run++; if (rv4 !== 1'b0) begin tests_failed++; $display("FAIL wr_pulse_one_cycle got=%b exp=0", rv4); end
    tests_run++; if (rdy4 !== 1'b1) begin tests_failed++; $display("FAIL wr_ready_idle got=%b exp=1", rdy4); end
  endtask

  task automatic test_read_after_write();
    int n, nr;
    drive_req(1'b0, 1'b0, 16'h0010, 16'hFFFF);
    wait_resp(1'b0, n, nr);
    tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL rd10_latency got=%0d exp=4", n); end
    tests_run++; if (rd4 !== 16'h1234) begin tests_failed++; $display("FAIL rd10_data got=%h exp=1234", rd4); end
    tests_run++; if (err4 !== 1'b0) begin tests_failed++; $display("FAIL rd10_err got=%b exp=0", err4); end
    step();
    tests_run++; if (rd4 !== 16'h1234) begin tests_failed++; $display("FAIL rd10_hold got=%h exp=1234", rd4); end
    drive_req(1'b0, 1'b0, 16'h0012, 16'h0000);
    wait_resp(1'b0, n, nr);
    tests_run++; if (rd4 !== 16'h0000) begin tests_failed++; $display("FAIL rd12_data got=%h exp=0000", rd4); end
    step();
  endtask

  task automatic test_errors();
    int n, nr;
    drive_req(1'b0, 1'b0, 16'h0011, 16'h0000);
    wait_resp(1'b0, n, nr);
    tests_run++; if (err4 !== 1'b1) begin tests_failed++; $display("FAIL odd_err got=%b exp=1", err4); end
    tests_run++; if (rd4 !== 16'h0000) begin tests_failed++; $display("FAIL odd_rdata got=%h exp=0000", rd4); end
    step();
    tests_run++; if (err4 !== 1'b1) begin tests_failed++; $display("FAIL odd_err_hold got=%b exp=1", err4); end
    drive_req(1'b0, 1'b1, 16'h0201, 16'h5555);
    wait_resp(1'b0, n, nr);
    tests_run++; if (err4 !== 1'b1) begin tests_failed++; $display("FAIL range_wr_err got=%b exp=1", err4); end
    step();
    // 0x0200 would alias word 0 if the range check were missing.
    drive_req(1'b0, 1'b1, 16'h0200, 16'h6666);
    wait_resp(1'b0, n, nr);
    tests_run++; if (err4 !== 1'b1) begin tests_failed++; $display("FAIL range_wr200_err got=%b exp=1", err4); end
    step();
    drive_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    wait_resp(1'b0, n, nr);
    tests_run++; if (err4 !== 1'b0) begin tests_failed++; $display("FAIL rd0_err got=%b exp=0", err4); end
    tests_run++; if (rd4 !== 16'h0000) begin tests_failed++; $display("FAIL rd0_unchanged got=%h exp=0000", rd4); end
    step();
  endtask

  task automatic test_back_to_back();
    int n, nr;
    drive_req(1'b0, 1'b1, 16'h0014, 16'h4321);
    wait_resp(1'b0, n, nr);
    // We are now in the write's RESP cycle; present the next request here.
    tests_run++; if (rdy4 !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_in_resp got=%b exp=1", rdy4); end
    drive_req(1'b0, 1'b0, 16'h0010, 16'h0000);
    tests_run++; if (busy4 !== 1'b1) begin tests_failed++; $display("FAIL b2b_accepted got=%b exp=1", busy4); end
    wait_resp(1'b0, n, nr);
    tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL b2b_latency got=%0d exp=4", n); end
    tests_run++; if (rd4 !== 16'h1234) begin tests_failed++; $display("FAIL b2b_rdata got=%h exp=1234", rd4); end
    drive_req(1'b0, 1'b0, 16'h0014, 16'h0000);
    wait_resp(1'b0, n, nr);
    tests_run++; if (rd4 !== 16'h4321) begin tests_failed++; $display("FAIL b2b_raw_rdata got=%h exp=4321", rd4); end
    step();
  endtask

  task automatic test_latency_one();
    int n, nr;
    drive_req(1'b1, 1'b1, 16'h00FE, 16'hBEEF);
    wait_resp(1'b1, n, nr);
    tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL l1_wr_latency got=%0d exp=1", n); end
    tests_run++; if (err1 !== 1'b0) begin tests_failed++; $display("FAIL l1_wr_err got=%b exp=0", err1); end
    tests_run++; if (rdy1 !== 1'b1) begin tests_failed++; $display("FAIL l1_ready_in_resp got=%b exp=1", rdy1); end
    drive_req(1'b1, 1'b0, 16'h00FE, 16'h0000);
    wait_resp(1'b1, n, nr);
    tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL l1_rd_latency got=%0d exp=1", n); end
    tests_run++; if (rd1 !== 16'hBEEF) begin tests_failed++; $display("FAIL l1_rd_data got=%h exp=beef", rd1); end
    step();
    tests_run++; if (rv1 !== 1'b0) begin tests_failed++; $display("FAIL l1_pulse_one_cycle got=%b exp=0", rv1); end
  endtask

  task automatic test_reset_abort();
    int n, nr;
    drive_req(1'b0, 1'b1, 16'h0020, 16'hAAAA);
    step();
    tests_run++; if (busy4 !== 1'b1) begin tests_failed++; $display("FAIL abort_mid_wait got=%b exp=1", busy4); end
    rst = 1'b0;
    #1;
    tests_run++; if (busy4 !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got=%b exp=0", busy4); end
    tests_run++; if (rdy4 !== 1'b1) begin tests_failed++; $display("FAIL abort_ready got=%b exp=1", rdy4); end
    tests_run++; if (rd4 !== 16'h0000) begin tests_failed++; $display("FAIL abort_rdata got=%h exp=0000", rd4); end
    // Keep reset low across the edge where the write would have completed.
    repeat (4) begin
      step();
      tests_run++; if (rv4 !== 1'b0) begin tests_failed++; $display("FAIL abort_no_resp got=%b exp=0", rv4); end
    end
    rst = 1'b1;
    step();
    drive_req(1'b0, 1'b0, 16'h0020, 16'h0000);
    wait_resp(1'b0, n, nr);
    tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL abort_rd20_latency got=%0d exp=4", n); end
    tests_run++; if (rd4 !== 16'h0000) begin tests_failed++; $display("FAIL abort_rd20_data got=%h exp=0000", rd4); end
    step();
    drive_req(1'b0, 1'b0, 16'h0010, 16'h0000);
    wait_resp(1'b0, n, nr);
    tests_run++; if (rd4 !== 16'h0000) begin tests_failed++; $display("FAIL abort_rd10_cleared got=%h exp=0000", rd4); end
    step();
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_read_after_write();
    test_errors();
    test_back_to_back();
    test_latency_one();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
